network_interface: RTL
======================

NETWORK_INTERFACE -- requirements
Module: network_interface

Interface
REQ-001 SHALL have parameter DATA_W, default 32, processor data word width.
REQ-002 SHALL have parameter ADDR_W, default 2, node address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, TX queue entries, power of two.
REQ-004 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 current_node  in  ADDR_W  this node's address.
REQ-007 proc_valid  in  1  processor presents a word to send; proc_dest_add  in  ADDR_W  destination; proc_data  in  DATA_W  payload.
REQ-008 mips_ni  out  1  NI can accept a processor word this cycle.
REQ-009 flit_out  out  DATA_W+2  flit to router; flit_out_valid  out  1; flit_out_ready  in  1.
REQ-010 flit_in  in  DATA_W+2  flit from router; flit_in_valid  in  1; flit_in_ready  out  1.
REQ-011 data_to_proc  out  DATA_W; src_add_out  out  ADDR_W; data_valid  out  1; proc_ready_in  in  1  processor accepts delivered word.
REQ-012 rx_err  out  1  sticky receive protocol/address error.

Function
REQ-013 Flit format SHALL be {type[1:0], payload[DATA_W-1:0]}; type HEAD=2'b01, TAIL=2'b10, others invalid.
REQ-014 HEAD payload SHALL be zero except [2*ADDR_W-1:ADDR_W]=source, [ADDR_W-1:0]=destination; TAIL payload = data word; every packet is exactly HEAD then TAIL.
REQ-015 mips_ni SHALL equal (TX FIFO not full) and be 0 while rst is high.
REQ-016 A word SHALL be enqueued {proc_dest_add, proc_data} on each edge where proc_valid && mips_ni; proc_valid while mips_ni=0 is ignored, never dropped silently into a full queue.
REQ-017 TX FSM states TX_IDLE, TX_HEAD, TX_TAIL; TX_IDLE with FIFO non-empty pops one entry into a holding register and moves to TX_HEAD.
REQ-018 TX_HEAD: flit_out_valid=1, flit_out=HEAD(src=current_node, dest=held dest); on flit_out_ready -> TX_TAIL.
REQ-019 TX_TAIL: flit_out_valid=1, flit_out=TAIL(held data); on flit_out_ready -> TX_IDLE.
REQ-020 Latency: word enqueued at edge k SHALL have HEAD valid from edge k+2 into an idle TX path; one idle cycle between consecutive packets.
REQ-021 flit_out SHALL be stable while flit_out_valid && !flit_out_ready; flit_out_valid=0 and flit_out=0 in TX_IDLE.
REQ-022 Enqueue and pop on the same edge SHALL both take effect; count unchanged.
REQ-023 RX FSM states RX_HEAD, RX_TAIL, RX_DROP, RX_DELIVER; flit transfers only when flit_in_valid && flit_in_ready.
REQ-024 flit_in_ready SHALL be 1 in RX_HEAD, RX_TAIL, RX_DROP and 0 in RX_DELIVER.
REQ-025 RX_HEAD: HEAD with dest==current_node captures source, -> RX_TAIL; HEAD with other dest sets rx_err, -> RX_DROP; non-HEAD flit consumed, sets rx_err, stays.
REQ-026 RX_TAIL: TAIL captures data, -> RX_DELIVER; HEAD sets rx_err and is processed as a new head per REQ-025; invalid type sets rx_err, -> RX_HEAD.
REQ-027 RX_DROP: TAIL consumed, -> RX_HEAD; any other type sets rx_err, -> RX_HEAD.
REQ-028 RX_DELIVER: data_valid=1, data_to_proc and src_add_out held stable; when proc_ready_in=1 -> RX_HEAD; data_valid=0 in all other states.
REQ-029 TX and RX paths SHALL operate concurrently and independently.

Reset
REQ-030 On rst: TX_IDLE, RX_HEAD, FIFO empty, holding/capture registers 0, rx_err 0, flit_out 0, flit_out_valid 0, data_valid 0, data_to_proc 0, src_add_out 0.
REQ-031 Reset mid-packet SHALL abandon partial TX/RX packets; no flit is emitted for queued words after reset.
REQ-032 rx_err SHALL clear only on reset.

Structure
REQ-033 Package ni_pkg SHALL hold flit type constants, TX/RX state encodings, and flit width derivation.
REQ-034 TX queue SHALL be sub-module sync_fifo (parameters width, depth; push, pop, full, empty, count).

Verification
REQ-035 Single send: current_node=1, proc_valid with dest=2, data=32'hDEADBEEF -> HEAD 34'h1_0000_0006 at k+2, then TAIL 34'h2_DEADBEEF.
REQ-036 Back-pressure: flit_out_ready=0 for 5 cycles, 5 words pushed -> mips_ni drops after 4 queued plus 1 held; flits stable; all 5 packets emitted in order.
REQ-037 Receive: node 1, HEAD(src 3,dest 1), TAIL 32'h12345678, proc_ready_in=0 for 3 cycles -> data_valid held 3+ cycles, src_add_out=3, flit_in_ready=0 until accepted.
REQ-038 Misaddressed: HEAD dest=2 at node 1 then TAIL -> no data_valid, rx_err=1, next good packet delivered.
REQ-039 Protocol errors: lone TAIL; HEAD,HEAD,TAIL -> rx_err=1, second packet delivered.
REQ-040 Reset asserted during TX_TAIL and RX_TAIL -> all outputs per REQ-030 immediately; FIFO empty after release.

Source files
------------

// File: rtl/ni_pkg.sv
// Shared definitions for the network interface: flit type tags, FSM state
// encodings and the flit width derived from the processor word width.
package ni_pkg;

  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_TAIL = 2'b10;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_HEAD,
    TX_TAIL
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_HEAD,
    RX_TAIL,
    RX_DROP,
    RX_DELIVER
  } rx_state_t;

  // A flit carries one payload word plus a two-bit type tag above it.
  function automatic int flit_width(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational read data at the head entry.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Simultaneous push and pop moves both pointers and leaves count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/network_interface.sv
// Processor-to-NoC interface: queues processor words and sends each as a
// HEAD/TAIL packet; receives HEAD/TAIL packets and hands the word to the processor.
module network_interface
  import ni_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_W-1:0]             current_node,
  input  logic                          proc_valid,
  input  logic [ADDR_W-1:0]             proc_dest_add,
  input  logic [DATA_W-1:0]             proc_data,
  output logic                          mips_ni,
  output logic [flit_width(DATA_W)-1:0] flit_out,
  output logic                          flit_out_valid,
  input  logic                          flit_out_ready,
  input  logic [flit_width(DATA_W)-1:0] flit_in,
  input  logic                          flit_in_valid,
  output logic                          flit_in_ready,
  output logic [DATA_W-1:0]             data_to_proc,
  output logic [ADDR_W-1:0]             src_add_out,
  output logic                          data_valid,
  input  logic                          proc_ready_in,
  output logic                          rx_err
);

  localparam int FLIT_W  = flit_width(DATA_W);
  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CW      = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] FIFO_FULL_COUNT = (CW + 1)'(FIFO_DEPTH);

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_dout;
  logic [CW:0]        fifo_count;

  assign mips_ni   = !rst && !fifo_full;
  assign fifo_push = proc_valid && mips_ni;

  sync_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .din  ({proc_dest_add, proc_data}),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  full_matches_count: assert property (@(posedge clk) disable iff (rst)
    fifo_full == (fifo_count == FIFO_FULL_COUNT));

  tx_state_t         tx_state;
  tx_state_t         tx_next;
  logic [ADDR_W-1:0] hold_dest;
  logic [DATA_W-1:0] hold_data;
  logic [DATA_W-1:0] head_payload;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      hold_dest <= '0;
      hold_data <= '0;
    end else begin
      tx_state <= tx_next;
      if (fifo_pop) {hold_dest, hold_data} <= fifo_dout;
    end
  end

  always_comb begin
    head_payload = '0;
    head_payload[2*ADDR_W-1:ADDR_W] = current_node;
    head_payload[ADDR_W-1:0]        = hold_dest;
  end

  // The flit is a pure function of state and held entry, so it stays put under back-pressure.
  always_comb begin
    tx_next        = tx_state;
    fifo_pop       = 1'b0;
    flit_out       = '0;
    flit_out_valid = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          tx_next  = TX_HEAD;
        end
      end
      TX_HEAD: begin
        flit_out_valid = 1'b1;
        flit_out       = {FLIT_HEAD, head_payload};
        if (flit_out_ready) tx_next = TX_TAIL;
      end
      TX_TAIL: begin
        flit_out_valid = 1'b1;
        flit_out       = {FLIT_TAIL, hold_data};
        if (flit_out_ready) tx_next = TX_IDLE;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  rx_state_t         rx_state;
  rx_state_t         rx_next;
  logic [1:0]        in_type;
  logic [ADDR_W-1:0] in_src;
  logic [ADDR_W-1:0] in_dest;
  logic              in_xfer;
  logic              cap_src;
  logic              cap_data;
  logic              set_err;
  logic [ADDR_W-1:0] src_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;

  assign in_type       = flit_in[FLIT_W-1:DATA_W];
  assign in_src        = flit_in[2*ADDR_W-1:ADDR_W];
  assign in_dest       = flit_in[ADDR_W-1:0];
  assign flit_in_ready = (rx_state != RX_DELIVER);
  assign in_xfer       = flit_in_valid && flit_in_ready;

  // A HEAD arriving where a TAIL was due is an error but still starts a fresh packet.
  always_comb begin
    rx_next  = rx_state;
    cap_src  = 1'b0;
    cap_data = 1'b0;
    set_err  = 1'b0;
    case (rx_state)
      RX_HEAD, RX_TAIL: begin
        if (in_xfer) begin
          if (in_type == FLIT_HEAD) begin
            if (rx_state == RX_TAIL) set_err = 1'b1;
            if (in_dest == current_node) begin
              cap_src = 1'b1;
              rx_next = RX_TAIL;
            end else begin
              set_err = 1'b1;
              rx_next = RX_DROP;
            end
          end else if (rx_state == RX_TAIL && in_type == FLIT_TAIL) begin
            cap_data = 1'b1;
            rx_next  = RX_DELIVER;
          end else begin
            set_err = 1'b1;
            rx_next = RX_HEAD;
          end
        end
      end
      RX_DROP: begin
        if (in_xfer) begin
          if (in_type != FLIT_TAIL) set_err = 1'b1;
          rx_next = RX_HEAD;
        end
      end
      RX_DELIVER: begin
        if (proc_ready_in) rx_next = RX_HEAD;
      end
      default: rx_next = RX_HEAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_HEAD;
      src_q    <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      rx_state <= rx_next;
      if (cap_src)  src_q  <= in_src;
      if (cap_data) data_q <= flit_in[DATA_W-1:0];
      if (set_err)  err_q  <= 1'b1;
    end
  end

  assign data_valid   = (rx_state == RX_DELIVER);
  assign data_to_proc = data_q;
  assign src_add_out  = src_q;
  assign rx_err       = err_q;

endmodule
